// File: rtl/vec_lsu_agen.sv
// vec_lsu_agen: strided vector load/store address generator feeding the AXI
// memory queue. One command in flight at a time.
//   Loads : LD_ISSUE pushes len beat addresses, LD_WAIT forwards returned
//           beats to the VRF write port tagged with their element index.
//   Stores: ST_ISSUE pairs each VRF read beat with its address, ST_WAIT waits
//           for the queue's store completion flag.
// Optional build macro LSU_TIMEOUT_EN adds a 16-bit watchdog on both WAIT
// states; when it expires err pulses and the command is retired through FIN.
module vec_lsu_agen #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned DW_B           = DATA_WIDTH >> 3,
    parameter int unsigned LEN_BITS       = 9,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_store,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
    input  logic [LEN_BITS-1:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] vrf_rd_data,
    input  logic                  vrf_rd_valid,
    output logic                  vrf_rd_ready,
    output logic [DATA_WIDTH-1:0] vrf_wr_data,
    output logic [LEN_BITS-1:0]   vrf_wr_idx,
    output logic                  vrf_wr_valid,
    output logic [ADDR_WIDTH-1:0] q_addr,
    output logic [DATA_WIDTH-1:0] q_data,
    output logic [DW_B-1:0]       q_be,
    output logic                  q_req,
    output logic                  q_valid,
    output logic                  q_start,
    output logic                  q_ready,
    input  logic [DATA_WIDTH-1:0] q_ld_data,
    input  logic                  q_ld_valid,
    input  logic                  q_done_ld,
    input  logic                  q_done_st,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_WAIT,
        ST_ISSUE,
        ST_WAIT,
        FIN
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_nxt;
    logic [ADDR_WIDTH-1:0] stride_reg, stride_nxt;
    logic [LEN_BITS-1:0]   len_reg, len_nxt;
    logic [LEN_BITS-1:0]   beat_cnt, beat_nxt;
    logic [LEN_BITS-1:0]   ret_cnt, ret_nxt;
    logic                  last_beat;

`ifdef LSU_TIMEOUT_EN
    logic [15:0]           wdog, wdog_nxt;
    logic                  timeout;
`endif

    // Every beat is a full-width access.
    assign q_be = '1;

    // The issue phase ends on the beat whose pre-increment count is len-1.
    assign last_beat = (beat_cnt == (len_reg - LEN_BITS'(1)));

`ifdef LSU_TIMEOUT_EN
    assign timeout = ((state == LD_WAIT) || (state == ST_WAIT)) &&
                     (wdog == 16'(TIMEOUT_CYCLES));
`endif

    // State, command and counter registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_reg   <= '0;
            stride_reg <= '0;
            len_reg    <= '0;
            beat_cnt   <= '0;
            ret_cnt    <= '0;
`ifdef LSU_TIMEOUT_EN
            wdog       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            addr_reg   <= addr_nxt;
            stride_reg <= stride_nxt;
            len_reg    <= len_nxt;
            beat_cnt   <= beat_nxt;
            ret_cnt    <= ret_nxt;
`ifdef LSU_TIMEOUT_EN
            wdog       <= wdog_nxt;
`endif
        end
    end

    // Next-state, counter updates and all handshake outputs.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_reg;
        stride_nxt   = stride_reg;
        len_nxt      = len_reg;
        beat_nxt     = beat_cnt;
        ret_nxt      = ret_cnt;
`ifdef LSU_TIMEOUT_EN
        // Zero outside the WAIT states, so each WAIT entry starts from 0.
        wdog_nxt     = ((state == LD_WAIT) || (state == ST_WAIT)) ? (wdog + 16'd1) : '0;
`endif
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        vrf_rd_ready = 1'b0;
        vrf_wr_data  = '0;
        vrf_wr_idx   = '0;
        vrf_wr_valid = 1'b0;
        q_addr       = '0;
        q_data       = '0;
        q_req        = 1'b0;
        q_valid      = 1'b0;
        q_start      = 1'b0;
        q_ready      = 1'b0;
        done         = 1'b0;
        err          = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    addr_nxt   = cmd_base;
                    stride_nxt = cmd_stride;
                    len_nxt    = cmd_len;
                    beat_nxt   = '0;
                    ret_nxt    = '0;
                    if (cmd_len == '0) begin
                        state_nxt = FIN;
                    end else if (cmd_store) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = LD_ISSUE;
                    end
                end
            end

            LD_ISSUE: begin
                q_req    = 1'b1;
                q_addr   = addr_reg;
                addr_nxt = addr_reg + stride_reg;
                beat_nxt = beat_cnt + LEN_BITS'(1);
                if (last_beat) begin
                    state_nxt = LD_WAIT;
                end
            end

            LD_WAIT: begin
                q_ready = 1'b1;
                if (q_ld_valid) begin
                    vrf_wr_valid = 1'b1;
                    vrf_wr_data  = q_ld_data;
                    vrf_wr_idx   = ret_cnt;
                    ret_nxt      = ret_cnt + LEN_BITS'(1);
                end
                if (q_done_ld) begin
                    state_nxt = FIN;
                    err       = (ret_cnt != len_reg);
                end
`ifdef LSU_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = FIN;
                    err       = 1'b1;
                end
`endif
            end

            ST_ISSUE: begin
                vrf_rd_ready = 1'b1;
                q_valid      = vrf_rd_valid;
                q_data       = vrf_rd_data;
                q_addr       = addr_reg;
                if (vrf_rd_valid) begin
                    q_start  = (beat_cnt == '0);
                    addr_nxt = addr_reg + stride_reg;
                    beat_nxt = beat_cnt + LEN_BITS'(1);
                    if (last_beat) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (q_done_st) begin
                    state_nxt = FIN;
                end
`ifdef LSU_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = FIN;
                    err       = 1'b1;
                end
`endif
            end

            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_lsu_agen.sv
// Directed bench for vec_lsu_agen: load, store with bubbles, len=0, address
// wrap with load count mismatch, mid-command reset, and the WAIT-state hold
// (watchdog expiry when built with LSU_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_vec_lsu_agen;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 8;
    localparam int unsigned LB = 9;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_store;
    logic [AW-1:0] cmd_base, cmd_stride;
    logic [LB-1:0] cmd_len;
    logic [DW-1:0] vrf_rd_data;
    logic          vrf_rd_valid, vrf_rd_ready;
    logic [DW-1:0] vrf_wr_data;
    logic [LB-1:0] vrf_wr_idx;
    logic          vrf_wr_valid;
    logic [AW-1:0] q_addr;
    logic [DW-1:0] q_data;
    logic [BW-1:0] q_be;
    logic          q_req, q_valid, q_start, q_ready;
    logic [DW-1:0] q_ld_data;
    logic          q_ld_valid, q_done_ld, q_done_st;
    logic          busy, done, err;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    int unsigned   n_wait;
    logic [DW-1:0] exp_data;
    logic          st_v [4];
    logic [AW-1:0] st_a [4];
    logic          st_s [4];

    vec_lsu_agen #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .DW_B           (BW),
        .LEN_BITS       (LB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_store    (cmd_store),
        .cmd_base     (cmd_base),
        .cmd_stride   (cmd_stride),
        .cmd_len      (cmd_len),
        .vrf_rd_data  (vrf_rd_data),
        .vrf_rd_valid (vrf_rd_valid),
        .vrf_rd_ready (vrf_rd_ready),
        .vrf_wr_data  (vrf_wr_data),
        .vrf_wr_idx   (vrf_wr_idx),
        .vrf_wr_valid (vrf_wr_valid),
        .q_addr       (q_addr),
        .q_data       (q_data),
        .q_be         (q_be),
        .q_req        (q_req),
        .q_valid      (q_valid),
        .q_start      (q_start),
        .q_ready      (q_ready),
        .q_ld_data    (q_ld_data),
        .q_ld_valid   (q_ld_valid),
        .q_done_ld    (q_done_ld),
        .q_done_st    (q_done_st),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Offer one command while idle; returns just after the accepting edge.
    task automatic send_cmd(input logic st, input logic [AW-1:0] base,
                            input logic [AW-1:0] stride, input logic [LB-1:0] len);
        cmd_valid  = 1'b1;
        cmd_store  = st;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_len    = len;
        settle();
        chk("accept_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0;
        cmd_base = '0; cmd_stride = '0; cmd_len = '0;
        vrf_rd_data = '0; vrf_rd_valid = 1'b0;
        q_ld_data = '0; q_ld_valid = 1'b0; q_done_ld = 1'b0; q_done_st = 1'b0;
        st_v = '{1'b1, 1'b0, 1'b1, 1'b1};
        st_a = '{32'h0000_2000, 32'h0000_1FF0, 32'h0000_1FF0, 32'h0000_1FE0};
        st_s = '{1'b1, 1'b0, 1'b0, 1'b0};
        tick(); tick();

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_q_req", q_req, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q_start", q_start, 0);
        chk("rst_q_ready", q_ready, 0);
        chk("rst_vrf_rd_ready", vrf_rd_ready, 0);
        chk("rst_vrf_wr_valid", vrf_wr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_q_be", q_be, 64'hFF);
        chk("rst_q_addr", q_addr, 0);
        rst_n = 1'b1;
        tick();

        // Load: base 0x1000, stride 8, len 4
        send_cmd(1'b0, 32'h1000, 32'd8, 9'd4);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("ld_q_req", q_req, 1);
            chk("ld_q_addr", q_addr, 64'h1000 + 64'(8 * i));
            chk("ld_busy", busy, 1);
            chk("ld_cmd_ready", cmd_ready, 0);
            tick();
        end
        settle();
        chk("ld_req_after4", q_req, 0);
        chk("ld_q_ready", q_ready, 1);
        for (int i = 0; i < 4; i++) begin
            exp_data   = 64'hCAFE_0000_0000_0000 + 64'(i);
            q_ld_valid = 1'b1;
            q_ld_data  = exp_data;
            settle();
            chk("ld_wr_valid", vrf_wr_valid, 1);
            chk("ld_wr_data", vrf_wr_data, exp_data);
            chk("ld_wr_idx", vrf_wr_idx, 64'(i));
            tick();
        end
        q_ld_valid = 1'b0;
        settle();
        chk("ld_wr_idle", vrf_wr_valid, 0);
        q_done_ld = 1'b1;
        settle();
        chk("ld_err_ok", err, 0);
        chk("ld_done_early", done, 0);
        tick();
        q_done_ld = 1'b0;
        settle();
        chk("ld_done", done, 1);
        chk("ld_fin_busy", busy, 1);
        tick();
        settle();
        chk("ld_done_1cyc", done, 0);
        chk("ld_idle_busy", busy, 0);
        chk("ld_idle_ready", cmd_ready, 1);

        // Stray queue responses while idle are ignored
        q_ld_valid = 1'b1; q_done_st = 1'b1;
        settle();
        chk("idle_wr_valid", vrf_wr_valid, 0);
        tick();
        q_ld_valid = 1'b0; q_done_st = 1'b0;
        settle();
        chk("idle_stays", busy, 0);
        chk("idle_no_done", done, 0);

        // Store: base 0x2000, stride -16, len 3, valid 1,0,1,1
        send_cmd(1'b1, 32'h2000, 32'hFFFF_FFF0, 9'd3);
        for (int i = 0; i < 4; i++) begin
            exp_data     = 64'h5700_0000_0000_0000 + 64'(i);
            vrf_rd_valid = st_v[i];
            vrf_rd_data  = exp_data;
            settle();
            chk("st_rd_ready", vrf_rd_ready, 1);
            chk("st_q_valid", q_valid, st_v[i]);
            chk("st_q_addr", q_addr, st_a[i]);
            chk("st_q_start", q_start, st_s[i]);
            chk("st_q_data", q_data, exp_data);
            tick();
        end
        vrf_rd_valid = 1'b0;
        settle();
        chk("st_wait_q_valid", q_valid, 0);
        chk("st_wait_rd_ready", vrf_rd_ready, 0);
        chk("st_wait_busy", busy, 1);
        q_done_ld = 1'b1;
        settle();
        chk("st_wait_err", err, 0);
        tick();
        q_done_ld = 1'b0;
        settle();
        chk("st_ignore_ld_done", done, 0);
        chk("st_still_busy", busy, 1);
        q_done_st = 1'b1;
        tick();
        q_done_st = 1'b0;
        settle();
        chk("st_done", done, 1);
        tick();
        settle();
        chk("st_idle_ready", cmd_ready, 1);

        // len = 0: straight to FIN, nothing issued
        send_cmd(1'b0, 32'h5000, 32'd8, 9'd0);
        settle();
        chk("len0_done", done, 1);
        chk("len0_q_req", q_req, 0);
        chk("len0_q_valid", q_valid, 0);
        tick();
        settle();
        chk("len0_done_1cyc", done, 0);
        chk("len0_ready", cmd_ready, 1);
        chk("len0_q_req2", q_req, 0);

        // Address wrap, then completion with one of two beats -> err
        send_cmd(1'b0, 32'hFFFF_FFF8, 32'd8, 9'd2);
        settle();
        chk("wrap_addr0", q_addr, 64'hFFFF_FFF8);
        tick();
        settle();
        chk("wrap_addr1", q_addr, 64'h0000_0000);
        chk("wrap_q_req1", q_req, 1);
        tick();
        q_ld_valid = 1'b1;
        q_ld_data  = 64'h1111_2222_3333_4444;
        settle();
        chk("wrap_wr_idx", vrf_wr_idx, 0);
        tick();
        q_ld_valid = 1'b0;
        q_done_ld  = 1'b1;
        settle();
        chk("mismatch_err", err, 1);
        tick();
        q_done_ld = 1'b0;
        settle();
        chk("mismatch_done", done, 1);
        chk("mismatch_err_1cyc", err, 0);
        tick();

        // Reset during LD_ISSUE beat 2 of 5
        send_cmd(1'b0, 32'h3000, 32'd4, 9'd5);
        tick();
        tick();
        settle();
        chk("mid_beat2_addr", q_addr, 64'h3008);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("mid_rst_q_req", q_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        send_cmd(1'b0, 32'h4000, 32'h10, 9'd1);
        settle();
        chk("post_rst_req", q_req, 1);
        chk("post_rst_addr", q_addr, 64'h4000);
        tick();
        settle();
        chk("post_rst_req_end", q_req, 0);
        q_ld_valid = 1'b1;
        q_ld_data  = 64'hDEAD_BEEF_0000_0001;
        settle();
        chk("post_rst_wr_idx", vrf_wr_idx, 0);
        chk("post_rst_wr_data", vrf_wr_data, 64'hDEAD_BEEF_0000_0001);
        tick();
        q_ld_valid = 1'b0;
        q_done_ld  = 1'b1;
        settle();
        chk("post_rst_err", err, 0);
        tick();
        q_done_ld = 1'b0;
        settle();
        chk("post_rst_done", done, 1);
        tick();

        // Store len 1 with q_done_st withheld
        send_cmd(1'b1, 32'h6000, 32'd8, 9'd1);
        vrf_rd_valid = 1'b1;
        vrf_rd_data  = 64'h0123_4567_89AB_CDEF;
        settle();
        chk("hold_q_start", q_start, 1);
        chk("hold_q_addr", q_addr, 64'h6000);
        tick();
        vrf_rd_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        // First cycle in ST_WAIT counts as 0; err expected 16 cycles later.
        n_wait = 0;
        settle();
        while ((err !== 1'b1) && (n_wait < 64)) begin
            tick();
            n_wait++;
        end
        chk("to_latency", n_wait, TO);
        chk("to_err", err, 1);
        tick();
        settle();
        chk("to_done", done, 1);
        chk("to_err_1cyc", err, 0);
        tick();
        settle();
        chk("to_idle", cmd_ready, 1);
`else
        n_wait = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((busy !== 1'b1) || (err !== 1'b0) || (done !== 1'b0)) n_wait++;
        end
        chk("hold_busy", busy, 1);
        chk("hold_no_exit", n_wait, 0);
        q_done_st = 1'b1;
        tick();
        q_done_st = 1'b0;
        settle();
        chk("hold_release_done", done, 1);
        tick();
        settle();
        chk("hold_idle", cmd_ready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
